// File: rtl/tiny_riscv_lsu_pkg.sv
// Shared types and constants for the tiny-riscv load/store unit.
package tiny_riscv_lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned F3_BITS  = 3;
  localparam int unsigned OFF_BITS = 2;
  localparam int unsigned LANES    = XLEN / 8;

  // RV32I load/store funct3 encodings
  localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  // Fields of an accepted request still needed after the accept cycle
  typedef struct packed {
    logic [F3_BITS-1:0]  funct3;
    logic [OFF_BITS-1:0] offset;
  } lsu_req_t;

  // Misalignment, unknown funct3, or an unsigned-width store
  function automatic logic lsu_req_illegal(input logic                is_store,
                                           input logic [F3_BITS-1:0]  funct3,
                                           input logic [OFF_BITS-1:0] offset);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = offset[0];
      F3_W:        bad = (offset != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad || (is_store && funct3[2]);
  endfunction

endpackage

// File: rtl/tiny_riscv_load_align.sv
// Extracts and sign/zero-extends a load result from a memory word.
//   word     : raw 32-bit memory word
//   offset   : byte offset addr[1:0] of the load
//   funct3   : RV32I load width/signedness
//   result_c : extended load value (0 for unsupported funct3)
module tiny_riscv_load_align
  import tiny_riscv_lsu_pkg::*;
(
  input  logic [XLEN-1:0]     word,
  input  logic [OFF_BITS-1:0] offset,
  input  logic [F3_BITS-1:0]  funct3,
  output logic [XLEN-1:0]     result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    result_c = '0;
    case (funct3)
      F3_B:    result_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result_c = {24'd0, byte_sel};
      F3_H:    result_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result_c = {16'd0, half_sel};
      F3_W:    result_c = word;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/tiny_riscv_load_store_unit.sv
// Data-memory initiator for the tiny-riscv core: one load/store at a time,
// registered memory strobes, aligned and extended load data.
//   i_Clk, i_Reset            : clock, synchronous active-high reset
//   i_req_*                   : core request (valid, store flag, funct3, addr, rs2)
//   o_req_ready               : high only while idle
//   o_resp_*                  : one-cycle response pulse with data / error
//   o_mem_addr                : word-aligned byte address to memory
//   o_read_strobe             : one-cycle read enable, data returns next cycle
//   o_mem_write_data/_mask    : lane-replicated store data and byte enables
//   i_mem_data                : memory read word
// Response arrives 1 cycle after accept for errors, 2 for stores, 3 for loads.
module tiny_riscv_load_store_unit
  import tiny_riscv_lsu_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_req_valid,
  input  logic              i_req_is_store,
  input  logic [F3_BITS-1:0] i_req_funct3,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_store_data,
  output logic              o_req_ready,
  output logic              o_resp_valid,
  output logic [XLEN-1:0]   o_resp_load_data,
  output logic              o_resp_error,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic              o_read_strobe,
  output logic [XLEN-1:0]   o_mem_write_data,
  output logic [LANES-1:0]  o_mem_write_mask,
  input  logic [XLEN-1:0]   i_mem_data
);

  lsu_state_t       state;
  lsu_req_t         req_q;
  logic             illegal_c;
  logic [XLEN-1:0]  store_data_c;
  logic [LANES-1:0] store_mask_c;
  logic [XLEN-1:0]  load_result_c;

  tiny_riscv_load_align u_align (
    .word     (i_mem_data),
    .offset   (req_q.offset),
    .funct3   (req_q.funct3),
    .result_c (load_result_c)
  );

  // Request legality and store lane fan-out, evaluated on the incoming request
  always_comb begin
    illegal_c    = lsu_req_illegal(i_req_is_store, i_req_funct3, i_req_addr[1:0]);
    store_data_c = i_req_store_data;
    store_mask_c = 4'b1111;
    case (i_req_funct3[1:0])
      2'b00: begin
        store_data_c = {4{i_req_store_data[7:0]}};
        store_mask_c = 4'b0001 << i_req_addr[1:0];
      end
      2'b01: begin
        store_data_c = {2{i_req_store_data[15:0]}};
        store_mask_c = i_req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Request sequencer; every output is a register updated alongside state
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state            <= ST_IDLE;
      req_q            <= '0;
      o_req_ready      <= 1'b1;
      o_resp_valid     <= 1'b0;
      o_resp_error     <= 1'b0;
      o_resp_load_data <= '0;
      o_mem_addr       <= '0;
      o_mem_write_data <= '0;
      o_read_strobe    <= 1'b0;
      o_mem_write_mask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            req_q       <= '{funct3: i_req_funct3, offset: i_req_addr[1:0]};
            o_req_ready <= 1'b0;
            if (illegal_c) begin
              // Errors skip the memory entirely
              state            <= ST_RESP;
              o_resp_valid     <= 1'b1;
              o_resp_error     <= 1'b1;
              o_resp_load_data <= '0;
            end else if (i_req_is_store) begin
              state            <= ST_WRITE;
              o_mem_addr       <= {i_req_addr[31:2], 2'b00};
              o_mem_write_data <= store_data_c;
              o_mem_write_mask <= store_mask_c;
            end else begin
              state         <= ST_READ;
              o_mem_addr    <= {i_req_addr[31:2], 2'b00};
              o_read_strobe <= 1'b1;
            end
          end
        end
        ST_READ: begin
          o_read_strobe <= 1'b0;
          state         <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Memory word is valid this cycle, one cycle after the strobe
          o_resp_load_data <= load_result_c;
          o_resp_valid     <= 1'b1;
          o_resp_error     <= 1'b0;
          state            <= ST_RESP;
        end
        ST_WRITE: begin
          o_mem_write_mask <= '0;
          o_resp_load_data <= '0;
          o_resp_valid     <= 1'b1;
          o_resp_error     <= 1'b0;
          state            <= ST_RESP;
        end
        ST_RESP: begin
          o_resp_valid <= 1'b0;
          o_resp_error <= 1'b0;
          o_req_ready  <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          o_read_strobe    <= 1'b0;
          o_mem_write_mask <= '0;
          o_resp_valid     <= 1'b0;
          o_resp_error     <= 1'b0;
          o_req_ready      <= 1'b1;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_riscv_load_store_unit.sv
// Scoreboard bench for tiny_riscv_load_store_unit with a word memory model
// and a byte-level reference model.
module tb_tiny_riscv_load_store_unit;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_is_store = 1'b0;
  logic [2:0]  i_req_funct3 = 3'd0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_store_data = 32'd0;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [31:0] o_resp_load_data;
  logic        o_resp_error;
  logic [31:0] o_mem_addr;
  logic        o_read_strobe;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_write_mask;
  logic [31:0] i_mem_data;

  always #5 i_Clk = ~i_Clk;

  tiny_riscv_load_store_unit dut (
    .i_Clk            (i_Clk),
    .i_Reset          (i_Reset),
    .i_req_valid      (i_req_valid),
    .i_req_is_store   (i_req_is_store),
    .i_req_funct3     (i_req_funct3),
    .i_req_addr       (i_req_addr),
    .i_req_store_data (i_req_store_data),
    .o_req_ready      (o_req_ready),
    .o_resp_valid     (o_resp_valid),
    .o_resp_load_data (o_resp_load_data),
    .o_resp_error     (o_resp_error),
    .o_mem_addr       (o_mem_addr),
    .o_read_strobe    (o_read_strobe),
    .o_mem_write_data (o_mem_write_data),
    .o_mem_write_mask (o_mem_write_mask),
    .i_mem_data       (i_mem_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Word memory: registered read, byte-masked write
  logic [31:0] mem [0:255];
  logic [31:0] mem_rdata;
  logic        mem_clear = 1'b0;

  always @(posedge i_Clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (o_mem_write_mask[b]) mem[o_mem_addr[9:2]][8*b +: 8] <= o_mem_write_data[8*b +: 8];
    end
    if (o_read_strobe) mem_rdata <= mem[o_mem_addr[9:2]];
  end
  assign i_mem_data = mem_rdata;

  // Byte-addressed reference memory, written only by the stimulus
  logic [7:0] ref_mem [0:1023];

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (st && f3[2]) return 1'b1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(f3); i++) ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
  endtask

  // Scoreboard entries
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int          strobe_cnt = 0;
  int          mask_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] last_strobe_addr = 32'd0;
  logic [3:0]  last_mask = 4'd0;
  logic [31:0] last_wdata = 32'd0;

  // Monitor: observes memory side and checks every response against the queue
  always @(negedge i_Clk) begin
    exp_t e;
    if (o_read_strobe === 1'b1 && o_mem_write_mask !== 4'd0) overlap_cnt++;
    if (o_read_strobe === 1'b1) begin
      strobe_cnt++;
      last_strobe_addr = o_mem_addr;
    end
    if (o_mem_write_mask !== 4'd0 && !$isunknown(o_mem_write_mask)) begin
      mask_cnt++;
      last_mask  = o_mem_write_mask;
      last_wdata = o_mem_write_data;
    end
    if (o_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got response data 0x%08h err %0b with none expected",
                 o_resp_load_data, o_resp_error);
      end else begin
        e = exp_q.pop_front();
        check32({e.name, "_data"}, o_resp_load_data, e.data);
        check32({e.name, "_err"}, 32'(o_resp_error), 32'(e.err));
        check32({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge i_Clk);
    while (o_req_ready !== 1'b1) begin
      @(negedge i_Clk);
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: o_req_ready stayed %0b for %0d cycles", o_req_ready, n);
        return;
      end
    end
  endtask

  // Issue one request; expected response goes to the scoreboard
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err,
                       input string name, input bit push, input bit spam);
    exp_t e;
    wait_ready();
    i_req_valid      = 1'b1;
    i_req_is_store   = st;
    i_req_funct3     = f3;
    i_req_addr       = a;
    i_req_store_data = d;
    @(posedge i_Clk);
    #1;
    i_req_valid = 1'b0;
    if (push) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.lat  = exp_err ? 1 : (st ? 2 : 3);
      e.acc  = cyc;
      e.name = name;
      exp_q.push_back(e);
    end
    if (st && !exp_err) ref_store(f3, a, d);
    if (spam) begin
      // Requests presented while busy must be ignored
      @(negedge i_Clk);
      while (o_req_ready === 1'b0) begin
        i_req_valid      = 1'b1;
        i_req_is_store   = 1'($urandom_range(0, 1));
        i_req_funct3     = 3'($urandom_range(0, 7));
        i_req_addr       = 32'($urandom_range(0, 1023));
        i_req_store_data = $urandom;
        @(negedge i_Clk);
      end
      i_req_valid = 1'b0;
    end
  endtask

  initial begin
    int s0, m0;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, d, ed;
    logic        ee;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
    mem_clear = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1 mem_clear = 1'b0;
    @(negedge i_Clk);
    check32("rst_ready",      32'(o_req_ready), 32'd1);
    check32("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check32("rst_resp_error", 32'(o_resp_error), 32'd0);
    check32("rst_load_data",  o_resp_load_data, 32'd0);
    check32("rst_mem_addr",   o_mem_addr, 32'd0);
    check32("rst_wdata",      o_mem_write_data, 32'd0);
    check32("rst_strobe",     32'(o_read_strobe), 32'd0);
    check32("rst_mask",       32'(o_mem_write_mask), 32'd0);
    i_Reset = 1'b0;

    // Preload word 0x100 through the store path
    issue(1'b1, 3'b010, 32'h100, 32'h84038201, 32'd0, 1'b0, "sw_preload", 1'b1, 1'b0);

    s0 = strobe_cnt;
    issue(1'b0, 3'b000, 32'h101, 32'd0, 32'hFFFFFF82, 1'b0, "lb_101", 1'b1, 1'b0);
    wait_ready();
    check32("lb_strobe_count", 32'(strobe_cnt - s0), 32'd1);
    check32("lb_strobe_addr", last_strobe_addr, 32'h100);

    issue(1'b0, 3'b100, 32'h103, 32'd0, 32'h00000084, 1'b0, "lbu_103", 1'b1, 1'b0);
    issue(1'b0, 3'b101, 32'h102, 32'd0, 32'h00008403, 1'b0, "lhu_102", 1'b1, 1'b0);
    issue(1'b0, 3'b001, 32'h100, 32'd0, 32'hFFFF8201, 1'b0, "lh_100", 1'b1, 1'b0);
    issue(1'b0, 3'b010, 32'h100, 32'd0, 32'h84038201, 1'b0, "lw_100", 1'b1, 1'b0);

    m0 = mask_cnt;
    issue(1'b1, 3'b000, 32'h105, 32'h000000AB, 32'd0, 1'b0, "sb_105", 1'b1, 1'b0);
    wait_ready();
    check32("sb_mask_count", 32'(mask_cnt - m0), 32'd1);
    check32("sb_mask", 32'(last_mask), 32'b0010);
    check32("sb_wdata", last_wdata, 32'hABABABAB);
    issue(1'b0, 3'b010, 32'h104, 32'd0, 32'h0000AB00, 1'b0, "lw_104", 1'b1, 1'b0);

    issue(1'b1, 3'b001, 32'h106, 32'h00001234, 32'd0, 1'b0, "sh_106", 1'b1, 1'b0);
    wait_ready();
    check32("sh_mask", 32'(last_mask), 32'b1100);
    check32("sh_wdata", last_wdata, 32'h12341234);

    // Errors never touch memory
    s0 = strobe_cnt;
    m0 = mask_cnt;
    issue(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 1'b1, "lw_misaligned", 1'b1, 1'b0);
    issue(1'b1, 3'b001, 32'h101, 32'h5555, 32'd0, 1'b1, "sh_misaligned", 1'b1, 1'b0);
    issue(1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 1'b1, "ld_f3_011", 1'b1, 1'b0);
    issue(1'b1, 3'b100, 32'h100, 32'h77, 32'd0, 1'b1, "st_f3_100", 1'b1, 1'b0);
    wait_ready();
    check32("err_strobe_count", 32'(strobe_cnt - s0), 32'd0);
    check32("err_mask_count", 32'(mask_cnt - m0), 32'd0);

    // Reset during CAPTURE aborts the load without a response
    issue(1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 1'b0, "aborted", 1'b0, 1'b0);
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    check32("abort_ready", 32'(o_req_ready), 32'd1);
    check32("abort_resp_valid", 32'(o_resp_valid), 32'd0);
    i_Reset = 1'b0;
    repeat (3) @(negedge i_Clk);
    issue(1'b0, 3'b010, 32'h104, 32'd0, 32'h1234AB00, 1'b0, "lw_after_abort", 1'b1, 1'b0);

    // Random stream against the reference model
    for (int n = 0; n < 1000; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      d  = $urandom;
      ee = ref_err(st, f3, a);
      ed = (ee || st) ? 32'd0 : ref_load(f3, a);
      issue(st, f3, a, d, ed, ee, "rand", 1'b1, (n % 3) == 0);
    end

    wait_ready();
    repeat (4) @(negedge i_Clk);
    check32("strobe_mask_overlap", 32'(overlap_cnt), 32'd0);
    check32("pending_responses", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
